// File: rtl/generic_mux.sv
// rtl/generic_mux.sv - four-input WIDTH-bit multiplexer with optional output register
//
// Purpose:
//   Steers one of in0..in3 onto o according to a 2-bit select.
//   REG_OUT=1 registers o with a one-cycle latency. o_valid then marks a value
//   that was captured on an enabled edge.
//   REG_OUT=0 gives a purely combinational path. That path is forced to
//   RESET_VAL while rst_n is low.
//
// Parameters:
//   WIDTH      data width of in0..in3 and o (>= 1)
//   REG_OUT    1 = registered output, 0 = combinational output
//   RESET_VAL  value driven on o during and after reset (sized to WIDTH)
//
// Ports:
//   clk      in   1      rising-edge clock (unused when REG_OUT=0)
//   rst_n    in   1      asynchronous active-low reset
//   en       in   1      update enable; qualifies sampling of sel/in*
//   sel      in   2      00=in0, 01=in1, 10=in2, 11=in3
//   in0..in3 in   WIDTH  data inputs
//   o        out  WIDTH  selected data
//   o_valid  out  1      o holds data selected under en=1

module generic_mux #(
  parameter int unsigned          WIDTH     = 1,
  parameter bit                   REG_OUT   = 1'b1,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  output logic [WIDTH-1:0] o,
  output logic             o_valid
);

  // Combinational select. All four codes are decoded, so no code is out of range.
  logic [WIDTH-1:0] mux_c;

  always_comb begin
    mux_c = in0;
    case (sel)
      2'b00:   mux_c = in0;
      2'b01:   mux_c = in1;
      2'b10:   mux_c = in2;
      default: mux_c = in3;
    endcase
  end

  generate
    if (REG_OUT) begin : g_reg
      // o keeps its value on disabled edges. o_valid only reports whether the
      // most recent edge captured new data.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          o       <= RESET_VAL;
          o_valid <= 1'b0;
        end else if (en) begin
          o       <= mux_c;
          o_valid <= 1'b1;
        end else begin
          o_valid <= 1'b0;
        end
      end
    end else begin : g_comb
      // The clock has no role in the combinational variant.
      // en only qualifies o_valid; it does not gate o.
      logic unused_clk;
      assign unused_clk = clk;

      assign o       = rst_n ? mux_c : RESET_VAL;
      assign o_valid = rst_n & en;
    end
  endgenerate

endmodule

// File: tb/tb_generic_mux.sv
// tb/tb_generic_mux.sv - scoreboard bench for generic_mux, registered and combinational variants

module tb_generic_mux;

  localparam logic [7:0] RV_R8 = 8'h5A;
  localparam logic [7:0] RV_C8 = 8'hC3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0;
  logic [1:0] sel = 2'b00;
  logic [7:0] d0 = '0, d1 = '0, d2 = '0, d3 = '0;

  logic [7:0] r8_o, c8_o;
  logic       r8_v, c8_v, r1_o, r1_v, c1_o, c1_v;

  always #5 clk = ~clk;

  generic_mux #(.WIDTH(8), .REG_OUT(1'b1), .RESET_VAL(RV_R8)) u_r8 (
    .clk(clk), .rst_n(rst_n), .en(en), .sel(sel),
    .in0(d0), .in1(d1), .in2(d2), .in3(d3), .o(r8_o), .o_valid(r8_v));

  generic_mux #(.WIDTH(8), .REG_OUT(1'b0), .RESET_VAL(RV_C8)) u_c8 (
    .clk(clk), .rst_n(rst_n), .en(en), .sel(sel),
    .in0(d0), .in1(d1), .in2(d2), .in3(d3), .o(c8_o), .o_valid(c8_v));

  generic_mux #(.WIDTH(1), .REG_OUT(1'b1), .RESET_VAL(1'b0)) u_r1 (
    .clk(clk), .rst_n(rst_n), .en(en), .sel(sel),
    .in0(d0[0]), .in1(d1[0]), .in2(d2[0]), .in3(d3[0]), .o(r1_o), .o_valid(r1_v));

  generic_mux #(.WIDTH(1), .REG_OUT(1'b0), .RESET_VAL(1'b0)) u_c1 (
    .clk(clk), .rst_n(rst_n), .en(en), .sel(sel),
    .in0(d0[0]), .in1(d1[0]), .in2(d2[0]), .in3(d3[0]), .o(c1_o), .o_valid(c1_v));

  typedef struct {
    logic [7:0] c8; logic c1; logic cv;
    logic [7:0] r8; logic r1; logic rv;
  } exp_t;

  exp_t comb_q[$];   // checked mid-cycle: combinational outputs plus current register state
  exp_t reg_q[$];    // checked just after each rising edge: registered outputs

  int n_chk  = 0;
  int n_fail = 0;

  // Reference state: what a registered output holds right now.
  logic [7:0] h8 = RV_R8;
  logic       h1 = 1'b0;
  logic       hv = 1'b0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Issue one cycle of stimulus.
  // r=0 holds reset for the whole cycle. pulse=1 drops rst_n only briefly,
  // between the falling edge and the next rising edge.
  task automatic step(input logic e, input logic [1:0] s,
                      input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] c, input logic [7:0] d,
                      input logic r, input bit pulse);
    logic [7:0] arr [4];
    logic [7:0] pick;
    bit         now_rst, edge_rst;
    exp_t       x;
    @(negedge clk);
    en = e; sel = s; d0 = a; d1 = b; d2 = c; d3 = d;
    rst_n = (r && !pulse);
    arr[0] = a; arr[1] = b; arr[2] = c; arr[3] = d;
    pick = arr[s];
    now_rst  = !r || pulse;
    edge_rst = !r && !pulse;
    if (now_rst) begin
      h8 = RV_R8; h1 = 1'b0; hv = 1'b0;
    end
    x.c8 = now_rst ? RV_C8 : pick;
    x.c1 = now_rst ? 1'b0 : pick[0];
    x.cv = !now_rst && e;
    x.r8 = h8; x.r1 = h1; x.rv = hv;
    comb_q.push_back(x);
    if (pulse) begin
      #4 rst_n = 1'b1;
    end
    if (!edge_rst) begin
      if (e) begin
        h8 = pick; h1 = pick[0]; hv = 1'b1;
      end else begin
        hv = 1'b0;
      end
    end
    x.r8 = h8; x.r1 = h1; x.rv = hv;
    reg_q.push_back(x);
  endtask

  // Monitors: compare whenever the DUT presents a settled output.
  initial begin : mon_comb
    exp_t x;
    forever begin
      @(negedge clk);
      #2;
      if (comb_q.size() > 0) begin
        x = comb_q.pop_front();
        chk("comb8_o", c8_o, x.c8);
        chk("comb8_valid", {7'd0, c8_v}, {7'd0, x.cv});
        chk("comb1_o", {7'd0, c1_o}, {7'd0, x.c1});
        chk("comb1_valid", {7'd0, c1_v}, {7'd0, x.cv});
        chk("reg8_o_async", r8_o, x.r8);
        chk("reg8_valid_async", {7'd0, r8_v}, {7'd0, x.rv});
        chk("reg1_o_async", {7'd0, r1_o}, {7'd0, x.r1});
      end
    end
  end

  initial begin : mon_reg
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (reg_q.size() > 0) begin
        x = reg_q.pop_front();
        chk("reg8_o", r8_o, x.r8);
        chk("reg8_valid", {7'd0, r8_v}, {7'd0, x.rv});
        chk("reg1_o", {7'd0, r1_o}, {7'd0, x.r1});
        chk("reg1_valid", {7'd0, r1_v}, {7'd0, x.rv});
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    logic [7:0] ra, rb, rc, rd;
    #1 rst_n = 1'b0;

    // Reset held with random data and en=1.
    for (int i = 0; i < 4; i++)
      step(1'b1, 2'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b0);

    // Selection sweep. bit0 of A5/3C/FF/00 is 1,0,1,0, which covers the 1-bit pattern too.
    step(1'b1, 2'b10, 8'hA5, 8'h3C, 8'hFF, 8'h00, 1'b1, 1'b0);
    step(1'b1, 2'b01, 8'hA5, 8'h3C, 8'hFF, 8'h00, 1'b1, 1'b0);
    step(1'b1, 2'b11, 8'hA5, 8'h3C, 8'hFF, 8'h00, 1'b1, 1'b0);
    step(1'b1, 2'b00, 8'hA5, 8'h3C, 8'hFF, 8'h00, 1'b1, 1'b0);

    // Hold under en=0, then re-enable.
    step(1'b1, 2'b10, 8'hA5, 8'h3C, 8'hFF, 8'h00, 1'b1, 1'b0);
    step(1'b0, 2'b01, 8'hA5, 8'h3C, 8'hFF, 8'h00, 1'b1, 1'b0);
    step(1'b0, 2'b01, 8'h11, 8'h22, 8'h33, 8'h44, 1'b1, 1'b0);
    step(1'b1, 2'b01, 8'hA5, 8'h3C, 8'hFF, 8'h00, 1'b1, 1'b0);

    // Mid-operation reset pulse between edges, then normal operation.
    step(1'b1, 2'b10, 8'hA5, 8'h3C, 8'hFF, 8'h00, 1'b1, 1'b0);
    step(1'b1, 2'b10, 8'hA5, 8'h3C, 8'hFF, 8'h00, 1'b1, 1'b1);
    step(1'b0, 2'b00, 8'hA5, 8'h3C, 8'hFF, 8'h00, 1'b1, 1'b1);
    step(1'b1, 2'b00, 8'hA5, 8'h3C, 8'hFF, 8'h00, 1'b1, 1'b0);

    // All 64 combinations of sel and the four 1-bit inputs. Upper bits are random.
    for (int k = 0; k < 64; k++) begin
      ra = {7'($urandom), k[0]};
      rb = {7'($urandom), k[1]};
      rc = {7'($urandom), k[2]};
      rd = {7'($urandom), k[3]};
      step(1'b1, k[5:4], ra, rb, rc, rd, 1'b1, 1'b0);
    end

    // Random traffic with occasional held resets and reset pulses.
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom), 2'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
           ($urandom_range(0, 19) != 0), ($urandom_range(0, 19) == 0));
    end

    // Drain both queues, then confirm nothing was left unchecked.
    @(negedge clk);
    @(negedge clk);
    #3;
    chk("comb_queue_drained", 8'(comb_q.size()), 8'd0);
    chk("reg_queue_drained", 8'(reg_q.size()), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
